// File: rtl/shm_pkg.sv
// Shared-memory arbiter package: address/word geometry, action encoding and
// the arbiter state enum shared by the arbiter and its round-robin picker.
package shm_pkg;

  localparam int SIZE      = 4;
  localparam int PROCSIZE  = 4;
  localparam int WORD_SIZE = 16;
  localparam int PAGE_SIZE = 2;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/shm_rr_pick.sv
// Combinational round-robin pick: first pending index strictly after
// last_grant, wrapping modulo N.
module shm_rr_pick
  import shm_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     pending,
  input  logic [IDX_W-1:0] last_grant,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // One extra bit holds last_grant + k before the modulo-N fold.
  always_comb begin
    valid = 1'b0;
    index = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      sum = {1'b0, last_grant} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N)) begin
        sum = sum - (IDX_W+1)'(N);
      end
      cand = sum[IDX_W-1:0];
      if (!valid && pending[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/shm_req_arbiter.sv
// Toggle-handshake arbiter that funnels per-processor copy requests to one
// DMA engine. Optional BUSY watchdog enabled by defining SHM_ARB_TIMEOUT_EN.
module shm_req_arbiter
  import shm_pkg::*;
#(
  parameter  int PROC_CNT       = 4,
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int IDX_W          = $clog2(PROC_CNT)
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [PROC_CNT-1:0]                trigger,
  input  logic [PROC_CNT-1:0]                action,
  input  logic [PROC_CNT-1:0][SIZE-1:0]      ptr,
  input  logic [PROC_CNT-1:0][PROCSIZE-1:0]  copy_start,
  input  logic [PROC_CNT-1:0][PROCSIZE-1:0]  copy_length,
  output logic [PROC_CNT-1:0]                ack,
  output logic                               dma_req,
  output logic [IDX_W-1:0]                   dma_proc,
  output logic                               dma_action,
  output logic [SIZE-1:0]                    dma_ptr,
  output logic [PROCSIZE-1:0]                dma_copy_start,
  output logic [PROCSIZE-1:0]                dma_copy_length,
  input  logic                               dma_done,
  output logic                               busy,
  output logic                               timeout_err
);

  arb_state_t          state, next_state;
  logic [PROC_CNT-1:0] seen;
  logic [PROC_CNT-1:0] pending;
  logic [IDX_W-1:0]    last_grant;
  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;
  logic                grant;
  logic                ack_fire;
  logic                tmo_hit;

  assign pending = trigger ^ seen;
  assign busy    = (state != IDLE);

  shm_rr_pick #(
    .N     (PROC_CNT),
    .IDX_W (IDX_W)
  ) u_pick (
    .pending    (pending),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .index      (pick_idx)
  );

`ifdef SHM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt;

  // Counter restarts on every entry to BUSY; the last counted cycle fires.
  assign tmo_hit = (state == BUSY) && !dma_done &&
                   (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == BUSY) begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end else begin
        tmo_cnt <= '0;
      end
      if (tmo_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    next_state = state;
    grant      = 1'b0;
    ack_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant      = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: next_state = BUSY;
      BUSY: begin
        if (dma_done || tmo_hit) begin
          ack_fire   = 1'b1;
          next_state = ACK;
        end
      end
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // dma_req is registered off ISSUE so the pulse lands two edges after the
  // request; ack flips on the edge into ACK, one edge after dma_done.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      seen            <= '0;
      ack             <= '0;
      dma_req         <= 1'b0;
      last_grant      <= IDX_W'(PROC_CNT - 1);
      dma_proc        <= '0;
      dma_action      <= READ;
      dma_ptr         <= '0;
      dma_copy_start  <= '0;
      dma_copy_length <= '0;
    end else begin
      state   <= next_state;
      dma_req <= (state == ISSUE);
      if (grant) begin
        seen[pick_idx]  <= trigger[pick_idx];
        last_grant      <= pick_idx;
        dma_proc        <= pick_idx;
        dma_action      <= action[pick_idx];
        dma_ptr         <= ptr[pick_idx];
        dma_copy_start  <= copy_start[pick_idx];
        dma_copy_length <= copy_length[pick_idx];
      end
      if (ack_fire) begin
        ack[dma_proc] <= ~ack[dma_proc];
      end
    end
  end

endmodule

// File: tb/tb_shm_req_arbiter.sv
// Directed, table-driven bench for shm_req_arbiter (PROC_CNT=4, TIMEOUT_CYCLES=8);
// covers both the default build and the SHM_ARB_TIMEOUT_EN build.
module tb_shm_req_arbiter;
  import shm_pkg::*;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [3:0]           trigger;
  logic [3:0]           action;
  logic [3:0][SIZE-1:0] ptr;
  logic [3:0][PROCSIZE-1:0] copy_start;
  logic [3:0][PROCSIZE-1:0] copy_length;
  logic [3:0]           ack;
  logic                 dma_req;
  logic [1:0]           dma_proc;
  logic                 dma_action;
  logic [SIZE-1:0]      dma_ptr;
  logic [PROCSIZE-1:0]  dma_copy_start;
  logic [PROCSIZE-1:0]  dma_copy_length;
  logic                 dma_done;
  logic                 busy;
  logic                 timeout_err;

  // Fixed per-processor command fields; proc 2 carries the reference request.
  logic [3:0] f_ptr   [4] = '{4'd1, 4'd9, 4'd5, 4'd3};
  logic [3:0] f_start [4] = '{4'd2, 4'd7, 4'd3, 4'd15};
  logic [3:0] f_len   [4] = '{4'd3, 4'd1, 4'd4, 4'd8};
  logic       f_act   [4] = '{READ, WRITE, WRITE, READ};

  typedef struct {
    bit         rst;
    logic [3:0] trig;
    logic       done;
    logic       e_busy;
    logic       e_req;
    logic [1:0] e_proc;
    logic [3:0] e_ack;
  } vec_t;

  vec_t vecs[$];
  int   n_applied    = 0;
  int   n_miscompare = 0;

  always #5 clock = ~clock;

  shm_req_arbiter #(
    .PROC_CNT       (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .trigger         (trigger),
    .action          (action),
    .ptr             (ptr),
    .copy_start      (copy_start),
    .copy_length     (copy_length),
    .ack             (ack),
    .dma_req         (dma_req),
    .dma_proc        (dma_proc),
    .dma_action      (dma_action),
    .dma_ptr         (dma_ptr),
    .dma_copy_start  (dma_copy_start),
    .dma_copy_length (dma_copy_length),
    .dma_done        (dma_done),
    .busy            (busy),
    .timeout_err     (timeout_err)
  );

  task automatic compareField(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_applied++;
    if (actual !== expected) begin
      n_miscompare++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
               name, actual, expected, $time);
    end
  endtask

  task automatic addVec(input bit rst, input logic [3:0] trig, input logic done,
                        input logic e_busy, input logic e_req,
                        input logic [1:0] e_proc, input logic [3:0] e_ack);
    vec_t v;
    v.rst = rst; v.trig = trig; v.done = done;
    v.e_busy = e_busy; v.e_req = e_req; v.e_proc = e_proc; v.e_ack = e_ack;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Inputs are driven just after an edge and take effect on the next one.
  task automatic applyStimulus(input vec_t v);
    if (v.rst) begin
      trigger = '0;
      reset   = 1'b1;
      #1;
      reset   = 1'b0;
    end
    trigger  = v.trig;
    dma_done = v.done;
    tick();
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    compareField({tag, ".busy"},        32'(busy),        32'(v.e_busy));
    compareField({tag, ".dma_req"},     32'(dma_req),     32'(v.e_req));
    compareField({tag, ".dma_proc"},    32'(dma_proc),    32'(v.e_proc));
    compareField({tag, ".ack"},         32'(ack),         32'(v.e_ack));
    compareField({tag, ".timeout_err"}, 32'(timeout_err), 32'd0);
    if (v.e_busy) begin
      compareField({tag, ".dma_action"},  32'(dma_action),      32'(f_act[v.e_proc]));
      compareField({tag, ".dma_ptr"},     32'(dma_ptr),         32'(f_ptr[v.e_proc]));
      compareField({tag, ".dma_start"},   32'(dma_copy_start),  32'(f_start[v.e_proc]));
      compareField({tag, ".dma_length"},  32'(dma_copy_length), 32'(f_len[v.e_proc]));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Single request from proc 2: grant, dma_req two edges later, ack after done.
    addVec(0, 4'b0000, 0, 0, 0, 2'd0, 4'b0000);
    addVec(0, 4'b0100, 0, 1, 0, 2'd2, 4'b0000);
    addVec(0, 4'b0100, 0, 1, 1, 2'd2, 4'b0000);
    addVec(0, 4'b0100, 1, 1, 0, 2'd2, 4'b0100);
    addVec(0, 4'b0100, 0, 0, 0, 2'd2, 4'b0100);
    addVec(0, 4'b0100, 0, 0, 0, 2'd2, 4'b0100);
    // dma_done while idle is ignored.
    addVec(0, 4'b0100, 1, 0, 0, 2'd2, 4'b0100);
    addVec(0, 4'b0100, 0, 0, 0, 2'd2, 4'b0100);
    // After reset, all four toggle at once: served 0,1,2,3.
    addVec(1, 4'b1111, 0, 1, 0, 2'd0, 4'b0000);
    addVec(0, 4'b1111, 0, 1, 1, 2'd0, 4'b0000);
    addVec(0, 4'b1111, 1, 1, 0, 2'd0, 4'b0001);
    addVec(0, 4'b1111, 0, 0, 0, 2'd0, 4'b0001);
    addVec(0, 4'b1111, 0, 1, 0, 2'd1, 4'b0001);
    addVec(0, 4'b1111, 0, 1, 1, 2'd1, 4'b0001);
    addVec(0, 4'b1111, 1, 1, 0, 2'd1, 4'b0011);
    addVec(0, 4'b1111, 0, 0, 0, 2'd1, 4'b0011);
    addVec(0, 4'b1111, 0, 1, 0, 2'd2, 4'b0011);
    addVec(0, 4'b1111, 0, 1, 1, 2'd2, 4'b0011);
    addVec(0, 4'b1111, 1, 1, 0, 2'd2, 4'b0111);
    addVec(0, 4'b1111, 0, 0, 0, 2'd2, 4'b0111);
    addVec(0, 4'b1111, 0, 1, 0, 2'd3, 4'b0111);
    addVec(0, 4'b1111, 0, 1, 1, 2'd3, 4'b0111);
    addVec(0, 4'b1111, 1, 1, 0, 2'd3, 4'b1111);
    addVec(0, 4'b1111, 0, 0, 0, 2'd3, 4'b1111);
    addVec(0, 4'b1111, 0, 0, 0, 2'd3, 4'b1111);
    // Proc 3 double-toggles while proc 0 is served: request cancelled.
    addVec(0, 4'b1110, 0, 1, 0, 2'd0, 4'b1111);
    addVec(0, 4'b0110, 0, 1, 1, 2'd0, 4'b1111);
    addVec(0, 4'b1110, 0, 1, 0, 2'd0, 4'b1111);
    addVec(0, 4'b1110, 1, 1, 0, 2'd0, 4'b1110);
    addVec(0, 4'b1110, 0, 0, 0, 2'd0, 4'b1110);
    addVec(0, 4'b1110, 0, 0, 0, 2'd0, 4'b1110);
    // Proc 1 re-toggles during its own BUSY: served again after ACK.
    addVec(0, 4'b1100, 0, 1, 0, 2'd1, 4'b1110);
    addVec(0, 4'b1100, 0, 1, 1, 2'd1, 4'b1110);
    addVec(0, 4'b1110, 0, 1, 0, 2'd1, 4'b1110);
    addVec(0, 4'b1110, 1, 1, 0, 2'd1, 4'b1100);
    addVec(0, 4'b1110, 0, 0, 0, 2'd1, 4'b1100);
    addVec(0, 4'b1110, 0, 1, 0, 2'd1, 4'b1100);
    addVec(0, 4'b1110, 0, 1, 1, 2'd1, 4'b1100);
    addVec(0, 4'b1110, 1, 1, 0, 2'd1, 4'b1110);
    addVec(0, 4'b1110, 0, 0, 0, 2'd1, 4'b1110);
    // Same, but proc 2 also pending: round-robin serves 2 before 1 again.
    addVec(0, 4'b1100, 0, 1, 0, 2'd1, 4'b1110);
    addVec(0, 4'b1010, 0, 1, 1, 2'd1, 4'b1110);
    addVec(0, 4'b1010, 1, 1, 0, 2'd1, 4'b1100);
    addVec(0, 4'b1010, 0, 0, 0, 2'd1, 4'b1100);
    addVec(0, 4'b1010, 0, 1, 0, 2'd2, 4'b1100);
    addVec(0, 4'b1010, 0, 1, 1, 2'd2, 4'b1100);
    addVec(0, 4'b1010, 1, 1, 0, 2'd2, 4'b1000);
    addVec(0, 4'b1010, 0, 0, 0, 2'd2, 4'b1000);
    addVec(0, 4'b1010, 0, 1, 0, 2'd1, 4'b1000);
    addVec(0, 4'b1010, 0, 1, 1, 2'd1, 4'b1000);
    addVec(0, 4'b1010, 1, 1, 0, 2'd1, 4'b1010);
    addVec(0, 4'b1010, 0, 0, 0, 2'd1, 4'b1010);
    addVec(0, 4'b1010, 0, 0, 0, 2'd1, 4'b1010);

    reset    = 1'b0;
    trigger  = '0;
    dma_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      action[i]      = f_act[i];
      ptr[i]         = f_ptr[i];
      copy_start[i]  = f_start[i];
      copy_length[i] = f_len[i];
    end
    #1 reset = 1'b1;
    #1;
    compareField("reset.busy",        32'(busy),            32'd0);
    compareField("reset.dma_req",     32'(dma_req),         32'd0);
    compareField("reset.ack",         32'(ack),             32'd0);
    compareField("reset.dma_proc",    32'(dma_proc),        32'd0);
    compareField("reset.dma_ptr",     32'(dma_ptr),         32'd0);
    compareField("reset.dma_length",  32'(dma_copy_length), 32'd0);
    compareField("reset.timeout_err", 32'(timeout_err),     32'd0);
    #1 reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d", i), vecs[i]);
    end

    // Reset while proc 0 is in BUSY: abort at once, no ack toggle.
    trigger = 4'b1011;
    tick();
    tick();
    compareField("rstbusy.pre_busy", 32'(busy),     32'd1);
    compareField("rstbusy.pre_req",  32'(dma_req),  32'd1);
    compareField("rstbusy.pre_proc", 32'(dma_proc), 32'd0);
    reset = 1'b1;
    #1;
    compareField("rstbusy.busy",    32'(busy),    32'd0);
    compareField("rstbusy.dma_req", 32'(dma_req), 32'd0);
    compareField("rstbusy.ack",     32'(ack),     32'd0);
    compareField("rstbusy.dma_ptr", 32'(dma_ptr), 32'd0);
    trigger = '0;
    #1 reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      dma_done = (c == 0);
      tick();
      compareField($sformatf("rstbusy.after%0d.busy", c), 32'(busy), 32'd0);
      compareField($sformatf("rstbusy.after%0d.ack", c),  32'(ack),  32'd0);
    end
    dma_done = 1'b0;

    // Proc 3 request that never sees dma_done.
    trigger = 4'b1000;
    tick();
    tick();
`ifdef SHM_ARB_TIMEOUT_EN
    for (int c = 0; c < 7; c++) begin
      tick();
      compareField($sformatf("tmo.wait%0d.busy", c), 32'(busy),        32'd1);
      compareField($sformatf("tmo.wait%0d.err", c),  32'(timeout_err), 32'd0);
      compareField($sformatf("tmo.wait%0d.ack", c),  32'(ack),         32'd0);
    end
    tick();
    compareField("tmo.fire.err",  32'(timeout_err), 32'd1);
    compareField("tmo.fire.ack",  32'(ack),         32'b1000);
    compareField("tmo.fire.busy", 32'(busy),        32'd1);
    tick();
    compareField("tmo.idle.busy", 32'(busy),        32'd0);
    compareField("tmo.idle.err",  32'(timeout_err), 32'd1);
    trigger = 4'b1001;
    tick();
    tick();
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    compareField("tmo.next.ack", 32'(ack),         32'b1001);
    compareField("tmo.next.err", 32'(timeout_err), 32'd1);
    tick();
    compareField("tmo.next.busy", 32'(busy),        32'd0);
    compareField("tmo.sticky",    32'(timeout_err), 32'd1);
    trigger = '0;
    reset   = 1'b1;
    #1;
    compareField("tmo.reset.err", 32'(timeout_err), 32'd0);
    reset = 1'b0;
`else
    for (int c = 0; c < 40; c++) begin
      tick();
      compareField($sformatf("wait%0d.busy", c), 32'(busy), 32'd1);
    end
    compareField("wait.err", 32'(timeout_err), 32'd0);
    compareField("wait.ack", 32'(ack),         32'd0);
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    compareField("wait.done.ack", 32'(ack), 32'b1000);
    tick();
    compareField("wait.done.busy", 32'(busy),        32'd0);
    compareField("wait.done.err",  32'(timeout_err), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
    $finish;
  end

endmodule

// File: doc/shm_req_arbiter.md
SHM_REQ_ARBITER -- requirements
Module: shm_req_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter PROC_CNT, default 4: number of requesting processors (2..16).
REQ-003 Parameter TIMEOUT_CYCLES, default 255: watchdog limit in clock cycles; used only with SHM_ARB_TIMEOUT_EN.
REQ-004 Port clock, in, 1: rising-edge clock shared with the DMA engine.
REQ-005 Port reset, in, 1: asynchronous active-high reset.
REQ-006 Port trigger, in, [PROC_CNT] x 1: per-processor request toggle; any change is one request.
REQ-007 Port action, in, [PROC_CNT] x 1: 0 = READ (shared memory to processor), 1 = WRITE (processor to shared memory).
REQ-008 Port ptr, in, [PROC_CNT] x SIZE: shared-memory word address.
REQ-009 Ports copy_start and copy_length, in, [PROC_CNT] x PROCSIZE: processor-memory start address and word count.
REQ-010 Port ack, out, [PROC_CNT] x 1: per-processor completion toggle.
REQ-011 Port dma_req, out, 1: single-cycle command pulse to the DMA engine.
REQ-012 Ports dma_proc (clog2(PROC_CNT)), dma_action (1), dma_ptr (SIZE), dma_copy_start and dma_copy_length (PROCSIZE), out: latched command fields.
REQ-013 Port dma_done, in, 1: single-cycle completion pulse from the DMA engine.
REQ-014 Port busy, out, 1: high whenever the state is not IDLE.
REQ-015 Port timeout_err, out, 1: sticky watchdog flag.

Function
REQ-016 pending[i] SHALL equal trigger[i] XOR seen[i], where seen is an internal register per processor.
REQ-017 The state machine SHALL use four states: IDLE, ISSUE, BUSY, ACK.
REQ-018 In IDLE with any pending, the block SHALL grant the first pending index after last_grant, wrapping modulo PROC_CNT.
REQ-019 On grant, the block SHALL latch that processor's action, ptr, copy_start and copy_length into the dma_* outputs, set seen[i] to trigger[i], update last_grant, and move to ISSUE.
REQ-020 In ISSUE, dma_req SHALL be high for exactly one cycle; the next state is BUSY.
REQ-021 In BUSY, dma_done SHALL move the state to ACK; dma_done in any other state SHALL be ignored.
REQ-022 In ACK, ack[dma_proc] SHALL toggle for that cycle only; the next state is IDLE.
REQ-023 Latency from a trigger edge seen in IDLE to dma_req SHALL be 2 cycles; from dma_done to the ack toggle, 1 cycle.
REQ-024 dma_* fields SHALL stay stable from grant until the next grant.
REQ-025 A trigger toggle during service of the same processor SHALL become a new pending request after ACK.
REQ-026 A double toggle while not yet granted SHALL cancel the request.
REQ-027 An asynchronous reset mid-transfer SHALL abort immediately without an ack toggle.

Reset
REQ-028 On reset: state IDLE, seen/ack/dma_req/busy/timeout_err/dma_* all 0, last_grant = PROC_CNT-1 (processor 0 has first priority); trigger inputs are required to be 0 at reset release.

Configuration
REQ-029 SHM_ARB_TIMEOUT_EN defined: a counter runs in BUSY; on reaching TIMEOUT_CYCLES without dma_done, timeout_err SHALL set (sticky until reset), ack SHALL toggle and the state SHALL go to IDLE through ACK.
REQ-030 SHM_ARB_TIMEOUT_EN undefined: no counter; timeout_err SHALL be tied to 0; BUSY waits indefinitely.

Structure
REQ-031 Package shm_pkg SHALL hold SIZE=4, PROCSIZE=4, WORD_SIZE=16, PAGE_SIZE=2, the READ=0/WRITE=1 action encoding and the arbiter state enum.
REQ-032 The round-robin priority pick SHALL be a combinational sub-module named shm_rr_pick (inputs pending and last_grant; outputs valid and index).

Verification
REQ-033 Proc 2 toggles trigger (action=1, ptr=5, start=3, length=4) -> dma_req 2 cycles later with dma_proc=2 and those fields; dma_done -> ack[2] toggles 1 cycle later.
REQ-034 All 4 procs toggle in the same cycle, with immediate dma_done each time -> grants in the order 0, 1, 2, 3, with exactly one ack toggle each.
REQ-035 Proc 1 is re-toggled during its own BUSY -> a second grant to proc 1 after ACK, unless another processor is next in round-robin order.
REQ-036 dma_done pulsed in IDLE -> no state change and no ack toggle.
REQ-037 Reset asserted in BUSY -> busy=0 and dma_req=0 immediately; no ack toggles.
REQ-038 With SHM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, no dma_done -> timeout_err=1 after 8 BUSY cycles, ack toggles, busy drops; the flag stays set until reset.
